// File: rtl/snn_stim_seq.sv
// Stimulus sequencer for a small spiking network: plays STEP, BURST and RAND
// scenes on two spike inputs, separated by fixed idle gaps.
module snn_stim_seq #(
    parameter int CNT_W      = 16,
    parameter int GAP_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] step_len,
    input  logic [CNT_W-1:0] step_delay,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [CNT_W-1:0] burst_period,
    input  logic [CNT_W-1:0] burst_on,
    input  logic [CNT_W-1:0] rand_len,
    input  logic [31:0]      rand_seed,
    input  logic [15:0]      thr0,
    input  logic [15:0]      thr1,
    output logic             in0_spike,
    output logic             in1_spike,
    output logic [2:0]       scene,
    output logic [CNT_W-1:0] scene_cycle,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_GAP   = 3'd2,
        S_BURST = 3'd3,
        S_RAND  = 3'd4
    } scene_e;

    typedef struct packed {
        logic [CNT_W-1:0] step_len;
        logic [CNT_W-1:0] step_delay;
        logic [CNT_W-1:0] burst_len;
        logic [CNT_W-1:0] burst_period;
        logic [CNT_W-1:0] burst_on;
        logic [CNT_W-1:0] rand_len;
        logic [31:0]      rand_seed;
        logic [15:0]      thr0;
        logic [15:0]      thr1;
    } cfg_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    scene_e           r_scene, r_last;
    scene_e           w_scene_nx;
    cfg_t             r_cfg;
    cfg_t             w_cfg_in, w_cfg;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cur_len;
    logic [CNT_W-1:0] r_phase, w_phase_nx, r_half, w_half_nx;
    logic [CNT_W-1:0] w_p, w_h_raw, w_h;
    logic [31:0]      r_lcg, w_lcg_nx, w_lcg_src, w_a, w_b;
    logic             r_in0, r_in1, r_busy, r_done;
    logic             w_in0_nx, w_in1_nx, w_done_nx, w_start_ok, w_enter;

    assign w_cfg_in = '{step_len: step_len, step_delay: step_delay,
                        burst_len: burst_len, burst_period: burst_period,
                        burst_on: burst_on, rand_len: rand_len,
                        rand_seed: rand_seed, thr0: thr0, thr1: thr1};

    // While idle the live inputs decide the first scene; afterwards only the latched copy counts.
    assign w_cfg      = (r_scene == S_IDLE) ? w_cfg_in : r_cfg;
    assign w_start_ok = (r_scene == S_IDLE) && start && !abort;

    // First non-empty main scene strictly after 'after' (S_IDLE means from the top).
    function automatic scene_e next_main(input scene_e after, input cfg_t c);
        if (after == S_IDLE && c.step_len != '0)
            return S_STEP;
        if ((after == S_IDLE || after == S_STEP) && c.burst_len != '0)
            return S_BURST;
        if (after != S_RAND && c.rand_len != '0)
            return S_RAND;
        return S_IDLE;
    endfunction

    always_comb begin
        case (r_scene)
            S_STEP:  w_cur_len = r_cfg.step_len;
            S_BURST: w_cur_len = r_cfg.burst_len;
            S_RAND:  w_cur_len = r_cfg.rand_len;
            default: w_cur_len = CNT_ONE;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_scene_nx = r_scene;
        w_cnt_nx   = r_cnt + CNT_ONE;
        case (r_scene)
            S_IDLE: begin
                if (w_start_ok)
                    w_scene_nx = next_main(S_IDLE, w_cfg);
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST)
                    w_scene_nx = next_main(r_last, w_cfg);
            end
            default: begin
                if (r_cnt == w_cur_len - CNT_ONE)
                    w_scene_nx = (GAP_CYCLES > 0) ? S_GAP : next_main(r_scene, w_cfg);
            end
        endcase
        if (abort && r_scene != S_IDLE)
            w_scene_nx = S_IDLE;

        w_enter = (w_scene_nx != r_scene);
        if (w_enter || w_scene_nx == S_IDLE)
            w_cnt_nx = '0;

        w_done_nx = (w_scene_nx == S_IDLE) &&
                    (w_start_ok || (r_scene != S_IDLE && !abort));
    end

    // Burst phase and half-period counters wrap instead of dividing.
    always_comb begin
        w_p        = (w_cfg.burst_period == '0) ? CNT_ONE : w_cfg.burst_period;
        w_h_raw    = w_p >> 1;
        w_h        = (w_h_raw == '0) ? CNT_ONE : w_h_raw;
        w_phase_nx = (w_enter || r_phase == w_p - CNT_ONE) ? '0 : r_phase + CNT_ONE;
        w_half_nx  = (w_enter || r_half == w_h - CNT_ONE) ? '0 : r_half + CNT_ONE;

        w_lcg_src = w_enter ? w_cfg.rand_seed : r_lcg;
        w_a       = 32'd1103515245 * w_lcg_src + 32'd12345;
        w_b       = 32'd1103515245 * w_a + 32'd6789;

        w_in0_nx = 1'b0;
        w_in1_nx = 1'b0;
        w_lcg_nx = r_lcg;
        case (w_scene_nx)
            S_STEP: w_in0_nx = (w_cnt_nx >= w_cfg.step_delay);
            S_BURST: begin
                w_in0_nx = (w_phase_nx < w_cfg.burst_on);
                w_in1_nx = (w_half_nx == '0);
            end
            S_RAND: begin
                w_in0_nx = (w_a[15:0] < w_cfg.thr0);
                w_in1_nx = (w_b[15:0] < w_cfg.thr1);
                w_lcg_nx = w_b;
            end
            default: ;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only, matching the rest of the codebase.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_scene <= S_IDLE;
            r_last  <= S_IDLE;
            r_cfg   <= '0;
            r_cnt   <= '0;
            r_phase <= '0;
            r_half  <= '0;
            r_lcg   <= '0;
            r_in0   <= 1'b0;
            r_in1   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
            r_scene <= w_scene_nx;
            r_cnt   <= w_cnt_nx;
            r_phase <= w_phase_nx;
            r_half  <= w_half_nx;
            r_lcg   <= w_lcg_nx;
            r_in0   <= w_in0_nx;
            r_in1   <= w_in1_nx;
            r_busy  <= (w_scene_nx != S_IDLE);
            r_done  <= w_done_nx;
            if (w_start_ok)
                r_cfg <= w_cfg_in;
            if (w_scene_nx inside {S_STEP, S_BURST, S_RAND})
                r_last <= w_scene_nx;
        end
    end

    assign scene       = r_scene;
    assign scene_cycle = r_cnt;
    assign in0_spike   = r_in0;
    assign in1_spike   = r_in1;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_snn_stim_seq.sv
// Self-checking bench for snn_stim_seq: table of directed runs, randomized runs
// against a per-cycle scene model, plus abort and mid-run reset sequences.
module tb_snn_stim_seq;

    localparam int CNT_W = 16;
    localparam int GAP   = 20;

    logic             clk = 1'b0;
    logic             rstn, start, abort;
    logic [CNT_W-1:0] step_len, step_delay, burst_len, burst_period, burst_on, rand_len;
    logic [31:0]      rand_seed;
    logic [15:0]      thr0, thr1;
    logic             in0_spike, in1_spike, busy, done;
    logic [2:0]       scene;
    logic [CNT_W-1:0] scene_cycle;

    typedef struct {
        int       step_len;
        int       step_delay;
        int       burst_len;
        int       burst_period;
        int       burst_on;
        int       rand_len;
        bit [31:0] seed;
        int       thr0;
        int       thr1;
    } cfg_t;

    typedef struct packed {
        logic [2:0]       scene;
        logic [CNT_W-1:0] cyc;
        logic             in0;
        logic             in1;
        logic             busy;
        logic             done;
    } obs_t;

    typedef struct {
        cfg_t c;
        int   in0;
        int   in1;
        int   busy;
    } vec_t;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    snn_stim_seq #(.CNT_W(CNT_W), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .step_len(step_len), .step_delay(step_delay),
        .burst_len(burst_len), .burst_period(burst_period), .burst_on(burst_on),
        .rand_len(rand_len), .rand_seed(rand_seed), .thr0(thr0), .thr1(thr1),
        .in0_spike(in0_spike), .in1_spike(in1_spike),
        .scene(scene), .scene_cycle(scene_cycle), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cfg_t mk(input int sl, input int sd, input int bl, input int bp,
                                input int bo, input int rl, input bit [31:0] seed,
                                input int t0, input int t1);
        cfg_t c;
        c.step_len = sl; c.step_delay = sd; c.burst_len = bl; c.burst_period = bp;
        c.burst_on = bo; c.rand_len = rl; c.seed = seed; c.thr0 = t0; c.thr1 = t1;
        return c;
    endfunction

    function automatic obs_t observe();
        return {scene, scene_cycle, in0_spike, in1_spike, busy, done};
    endfunction

    function automatic obs_t rec(input int sc, input int cyc, input bit i0, input bit i1,
                                 input bit b, input bit d);
        obs_t e;
        e.scene = 3'(sc); e.cyc = CNT_W'(cyc); e.in0 = i0; e.in1 = i1; e.busy = b; e.done = d;
        return e;
    endfunction

    // Expected observation for every cycle after start, straight from the scene rules.
    function automatic void build_expected(input cfg_t c);
        int        lens[3];
        int        codes[3];
        int        p, h;
        bit [31:0] s, a, b;
        bit        i0, i1;
        exp_q.delete();
        lens  = '{c.step_len, c.burst_len, c.rand_len};
        codes = '{1, 3, 4};
        for (int k = 0; k < 3; k++) begin
            if (lens[k] == 0) continue;
            s = c.seed;
            p = (c.burst_period == 0) ? 1 : c.burst_period;
            h = (p / 2 == 0) ? 1 : p / 2;
            for (int i = 0; i < lens[k]; i++) begin
                i0 = 1'b0;
                i1 = 1'b0;
                if (k == 0) begin
                    i0 = (i >= c.step_delay);
                end else if (k == 1) begin
                    i0 = ((i % p) < c.burst_on);
                    i1 = ((i % h) == 0);
                end else begin
                    a  = 32'd1103515245 * s + 32'd12345;
                    b  = 32'd1103515245 * a + 32'd6789;
                    i0 = (int'(a[15:0]) < c.thr0);
                    i1 = (int'(b[15:0]) < c.thr1);
                    s  = b;
                end
                exp_q.push_back(rec(codes[k], i, i0, i1, 1'b1, 1'b0));
            end
            for (int g = 0; g < GAP; g++)
                exp_q.push_back(rec(2, g, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        exp_q.push_back(rec(0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    endfunction

    task automatic apply_cfg(input cfg_t c);
        step_len     = CNT_W'(c.step_len);
        step_delay   = CNT_W'(c.step_delay);
        burst_len    = CNT_W'(c.burst_len);
        burst_period = CNT_W'(c.burst_period);
        burst_on     = CNT_W'(c.burst_on);
        rand_len     = CNT_W'(c.rand_len);
        rand_seed    = c.seed;
        thr0         = 16'(c.thr0);
        thr1         = 16'(c.thr1);
    endtask

    task automatic scramble_cfg();
        step_len     = CNT_W'($urandom);
        step_delay   = CNT_W'($urandom);
        burst_len    = CNT_W'($urandom);
        burst_period = CNT_W'($urandom);
        burst_on     = CNT_W'($urandom);
        rand_len     = CNT_W'($urandom);
        rand_seed    = $urandom;
        thr0         = 16'($urandom);
        thr1         = 16'($urandom);
    endtask

    // Start a run, compare every cycle through done, then one idle cycle.
    task automatic run_checked(input cfg_t c, input string tag,
                               output int n0, output int n1, output int nb, output int nd);
        obs_t o;
        n0 = 0; n1 = 0; nb = 0; nd = 0;
        build_expected(c);
        @(negedge clk);
        apply_cfg(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        foreach (exp_q[i]) begin
            o = observe();
            check($sformatf("%s cyc%0d", tag, i), 32'(o), 32'(exp_q[i]));
            n0 += int'(o.in0);
            n1 += int'(o.in1);
            nb += int'(o.busy);
            nd += int'(o.done);
            scramble_cfg();
            @(negedge clk);
        end
        check($sformatf("%s post_idle", tag), 32'(observe()), 32'(rec(0, 0, 0, 0, 0, 0)));
    endtask

    initial begin
        vec_t tbl[7];
        cfg_t c_full, c_rand, c;
        int   n0, n1, nb, nd;

        tbl[0] = '{mk(400, 10, 0, 0, 0, 0, 0, 0, 0), 390, 0, 420};
        tbl[1] = '{mk(0, 0, 400, 40, 4, 0, 0, 0, 0), 40, 20, 420};
        tbl[2] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0};
        tbl[3] = '{mk(5, 0, 7, 0, 1, 0, 0, 0, 0), 12, 7, 52};
        tbl[4] = '{mk(0, 0, 6, 5, 9, 0, 0, 0, 0), 6, 3, 26};
        tbl[5] = '{mk(0, 0, 0, 0, 0, 5, 32'hdeadbeef, 0, 0), 0, 0, 25};
        tbl[6] = '{mk(3, 5, 5, 2, 1, 0, 0, 0, 0), 3, 5, 48};
        c_full = mk(400, 10, 400, 40, 4, 800, 32'h12345678, 3000, 5000);
        c_rand = mk(0, 0, 0, 0, 0, 800, 32'h12345678, 3000, 5000);

        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        scramble_cfg();
        repeat (3) @(negedge clk);
        check("reset_state", 32'(observe()), 32'(rec(0, 0, 0, 0, 0, 0)));
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(observe()), 32'(rec(0, 0, 0, 0, 0, 0)));

        for (int v = 0; v < 7; v++) begin
            run_checked(tbl[v].c, $sformatf("vec%0d", v), n0, n1, nb, nd);
            check($sformatf("vec%0d in0_count", v), 32'(n0), 32'(tbl[v].in0));
            check($sformatf("vec%0d in1_count", v), 32'(n1), 32'(tbl[v].in1));
            check($sformatf("vec%0d busy_count", v), 32'(nb), 32'(tbl[v].busy));
            check($sformatf("vec%0d done_count", v), 32'(nd), 32'd1);
        end

        run_checked(c_rand, "lcg800", n0, n1, nb, nd);

        for (int r = 0; r < 12; r++) begin
            c = mk(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)),
                   int'($urandom_range(0, 45)),
                   ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)),
                   int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                   ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)),
                   $urandom, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            run_checked(c, $sformatf("rnd%0d", r), n0, n1, nb, nd);
            check($sformatf("rnd%0d done_count", r), 32'(nd), 32'd1);
        end

        // Abort at BURST scene_cycle 100 with a stray start pulse earlier in the run.
        build_expected(c_full);
        @(negedge clk);
        apply_cfg(c_full);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 520; i++) begin
            check($sformatf("abort_run cyc%0d", i), 32'(observe()), 32'(exp_q[i]));
            start = (i == 50);
            abort = (i == 520);
            @(negedge clk);
        end
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("after_abort %0d", i), 32'(observe()), 32'(rec(0, 0, 0, 0, 0, 0)));
            @(negedge clk);
        end
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_with_abort", 32'(observe()), 32'(rec(0, 0, 0, 0, 0, 0)));
        run_checked(c_full, "restart_full", n0, n1, nb, nd);
        check("restart_full done_count", 32'(nd), 32'd1);

        // Reset pulse at RAND scene_cycle 300, then the same run from the seed again.
        build_expected(c_rand);
        @(negedge clk);
        apply_cfg(c_rand);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 300; i++) begin
            check($sformatf("reset_run cyc%0d", i), 32'(observe()), 32'(exp_q[i]));
            rstn = (i != 300);
            @(negedge clk);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("after_reset %0d", i), 32'(observe()), 32'(rec(0, 0, 0, 0, 0, 0)));
            @(negedge clk);
        end
        run_checked(c_rand, "lcg_again", n0, n1, nb, nd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_stim_seq.md
SNN_STIM_SEQ -- requirements
Module: snn_stim_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of every length/count field and of scene_cycle.
REQ-002 SHALL have parameter GAP_CYCLES, default 20, idle cycles inserted after each non-skipped scene.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate run, return to IDLE.
REQ-007 SHALL have ports step_len, step_delay  input  CNT_W each  STEP scene length; in0 onset cycle.
REQ-008 SHALL have ports burst_len, burst_period, burst_on  input  CNT_W each  BURST scene length, period, in0 on-cycles per period.
REQ-009 SHALL have ports rand_len  input  CNT_W, rand_seed  input  32, thr0 and thr1  input  16  RAND scene length, LCG seed, spike thresholds.
REQ-010 SHALL have ports in0_spike, in1_spike  output  1 each  registered spike drive to the network inputs.
REQ-011 SHALL have ports scene  output  3 (IDLE=0, STEP=1, GAP=2, BURST=3, RAND=4), scene_cycle  output  CNT_W, busy  output  1, done  output  1.

Function
REQ-012 SHALL latch all config inputs when start is accepted; config changes during a run SHALL have no effect.
REQ-013 SHALL accept start only when scene==IDLE and abort==0; start while busy SHALL be ignored.
REQ-014 SHALL sequence STEP -> GAP -> BURST -> GAP -> RAND -> GAP -> IDLE.
REQ-015 SHALL hold each scene for exactly its length (GAP: GAP_CYCLES) cycles, scene_cycle counting 0..len-1 and resetting to 0 on every scene change.
REQ-016 SHALL skip any scene with length 0 together with its following GAP.
REQ-017 SHALL enter the first non-skipped scene in the cycle after start accepted, with scene_cycle=0; if all lengths are 0, SHALL return done in that cycle with scene=IDLE.
REQ-018 SHALL keep scene, scene_cycle, in0_spike, in1_spike mutually consistent: spikes in a cycle are the function of the scene/scene_cycle shown that same cycle.
REQ-019 STEP: in0_spike = (scene_cycle >= step_delay); in1_spike = 0.
REQ-020 BURST: phase p = scene_cycle mod P, P = max(burst_period,1); in0_spike = (p < burst_on); in1_spike = (scene_cycle mod H == 0), H = max(P>>1,1); implemented with wrapping counters, no divider.
REQ-021 RAND: state s loaded from rand_seed at scene entry; per cycle a = 1103515245*s+12345, b = 1103515245*a+6789 (mod 2^32); in0_spike = (a[15:0] < thr0), in1_spike = (b[15:0] < thr1); s <= b.
REQ-022 GAP and IDLE: in0_spike = in1_spike = 0.
REQ-023 busy SHALL be 1 from the first scene cycle through the last GAP cycle, else 0.
REQ-024 done SHALL pulse for exactly one cycle, the cycle scene returns to IDLE after normal completion.
REQ-025 abort while busy SHALL, in the next cycle, force scene=IDLE, scene_cycle=0, spikes 0, busy 0, with no done pulse; abort and start in the same IDLE cycle SHALL not start a run.

Reset
REQ-026 SHALL, when rstn==0 at a rising edge, set scene=IDLE, scene_cycle=0, in0_spike=0, in1_spike=0, busy=0, done=0, LCG state=0, including mid-run; no done pulse from a reset-terminated run.

Verification
REQ-027 step_len=400, step_delay=10, others 0 -> in0 low scene_cycle 0-9, high 10-399 (390 cycles), in1 never high, 20-cycle GAP, done at start+421.
REQ-028 burst_len=400, burst_period=40, burst_on=4, others 0 -> in0 high 40 cycles (4 at each multiple of 40), in1 high 20 cycles at scene_cycle multiples of 20.
REQ-029 rand_len=800, rand_seed=0x12345678, thr0=3000, thr1=5000 -> spikes bit-exact against LCG model of REQ-021 every cycle.
REQ-030 step_len=0, burst_len=0, rand_len=5 -> RAND entered in cycle after start, busy 25 cycles, done once, then IDLE.
REQ-031 full run (400/400/800), abort at BURST scene_cycle 100, start pulsed during run -> IDLE next cycle, spikes 0, no done, start ignored; new start after abort runs from STEP.
REQ-032 rstn low for 1 cycle at RAND scene_cycle 300 -> all outputs at reset values next cycle, no done; subsequent start reproduces REQ-029 sequence from seed.
